// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: debounces the decoder's key-held level, turns each clean
// press into one action, and maintains the three BCD display digits and the record flag.
module keypad_entry_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int          CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_val,
  input  logic       key_pressed,
  output logic [3:0] disp_val,
  output logic [3:0] disp_val2,
  output logic [3:0] disp_val3,
  output logic       is_record,
  output logic       key_strobe,
  output logic [3:0] last_key
);

  // state        | meaning
  // IDLE         | no key held, waiting for a rising key level
  // PRESS_WAIT   | key seen, waiting for level and code to stay stable
  // HELD         | press accepted and acted on, waiting for release
  // RELEASE_WAIT | key level low, waiting for it to stay low
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [15:0]      LAST_16  = DEBOUNCE_CYCLES - 16'd1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_16);

  localparam logic [3:0] KEY_RECORD = 4'hA;
  localparam logic [3:0] KEY_CLEAR  = 4'hC;
  localparam logic [3:0] KEY_BACK   = 4'hF;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       key_lat, key_lat_n;
  logic             commit;
  logic             cnt_done;

  logic [3:0] d1_n, d2_n, d3_n, last_key_n;
  logic       rec_n;

  assign cnt_done = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      key_lat <= 4'h0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      key_lat <= key_lat_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    key_lat_n = key_lat;
    commit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (key_pressed) begin
          state_n   = PRESS_WAIT;
          cnt_n     = '0;
          key_lat_n = key_val;
        end
      end
      PRESS_WAIT: begin
        if (!key_pressed) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (key_val != key_lat) begin
          // Code moved under a held key: restart the stability window on the new code.
          key_lat_n = key_val;
          cnt_n     = '0;
        end else if (cnt_done) begin
          state_n = HELD;
          cnt_n   = '0;
          commit  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!key_pressed) begin
          state_n = RELEASE_WAIT;
          cnt_n   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (key_pressed) begin
          state_n = HELD;
          cnt_n   = '0;
        end else if (cnt_done) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Action applied to the digit registers on the commit cycle.
  always_comb begin
    d1_n       = disp_val;
    d2_n       = disp_val2;
    d3_n       = disp_val3;
    rec_n      = is_record;
    last_key_n = last_key;
    if (commit) begin
      last_key_n = key_lat;
      if (key_lat < 4'd10) begin
        d1_n = disp_val2;
        d2_n = disp_val3;
        d3_n = key_lat;
      end else if (key_lat == KEY_RECORD) begin
        rec_n = ~is_record;
      end else if (key_lat == KEY_CLEAR) begin
        d1_n = 4'd0;
        d2_n = 4'd0;
        d3_n = 4'd0;
      end else if (key_lat == KEY_BACK) begin
        d3_n = disp_val2;
        d2_n = disp_val;
        d1_n = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_val   <= 4'd0;
      disp_val2  <= 4'd0;
      disp_val3  <= 4'd0;
      is_record  <= 1'b0;
      key_strobe <= 1'b0;
      last_key   <= 4'h0;
    end else begin
      disp_val   <= d1_n;
      disp_val2  <= d2_n;
      disp_val3  <= d3_n;
      is_record  <= rec_n;
      key_strobe <= commit;
      last_key   <= last_key_n;
    end
  end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: per-cycle comparison against a run-length press/release
// model, a table of press actions, hand-timed corner sequences and random key activity.
module tb_keypad_entry_ctrl;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] key_val = 4'h0;
  logic       key_pressed = 1'b0;
  logic [3:0] disp_val, disp_val2, disp_val3, last_key;
  logic       is_record, key_strobe;

  keypad_entry_ctrl #(.DEBOUNCE_CYCLES(16'd4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .key_val(key_val), .key_pressed(key_pressed),
    .disp_val(disp_val), .disp_val2(disp_val2), .disp_val3(disp_val3),
    .is_record(is_record), .key_strobe(key_strobe), .last_key(last_key)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int nstrobe = 0;

  // Reference model: a press is accepted after D+1 consecutive high samples with one
  // code; a release after D+1 consecutive low samples.
  logic       m_held;
  int         m_run, m_low;
  logic [3:0] m_key;
  logic [3:0] m_dig [3];
  logic       m_rec, m_strobe;
  logic [3:0] m_last;

  typedef struct {
    logic [3:0] key;
    logic [3:0] e1, e2, e3;
    logic       erec;
  } press_vec_t;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_held = 0; m_run = 0; m_low = 0; m_key = 0;
    m_dig[0] = 0; m_dig[1] = 0; m_dig[2] = 0;
    m_rec = 0; m_strobe = 0; m_last = 0;
  endtask

  task automatic model_commit(input logic [3:0] k);
    m_strobe = 1; m_last = k;
    if (k <= 9) begin
      m_dig[0] = m_dig[1]; m_dig[1] = m_dig[2]; m_dig[2] = k;
    end else if (k == 4'hA) m_rec = ~m_rec;
    else if (k == 4'hC) begin
      m_dig[0] = 0; m_dig[1] = 0; m_dig[2] = 0;
    end else if (k == 4'hF) begin
      m_dig[2] = m_dig[1]; m_dig[1] = m_dig[0]; m_dig[0] = 0;
    end
  endtask

  task automatic model_clock(input logic kp, input logic [3:0] kv);
    m_strobe = 0;
    if (!m_held) begin
      if (kp) begin
        if (m_run > 0 && kv == m_key) m_run++;
        else begin m_run = 1; m_key = kv; end
        if (m_run == D + 1) begin
          model_commit(m_key);
          m_held = 1; m_low = 0;
        end
      end else m_run = 0;
    end else begin
      if (!kp) begin
        m_low++;
        if (m_low == D + 1) begin m_held = 0; m_run = 0; end
      end else m_low = 0;
    end
  endtask

  task automatic check_model();
    chk("strobe", {3'b0, key_strobe}, {3'b0, m_strobe});
    chk("disp_val", disp_val, m_dig[0]);
    chk("disp_val2", disp_val2, m_dig[1]);
    chk("disp_val3", disp_val3, m_dig[2]);
    chk("is_record", {3'b0, is_record}, {3'b0, m_rec});
    chk("last_key", last_key, m_last);
  endtask

  task automatic step(input logic kp, input logic [3:0] kv);
    key_pressed = kp;
    key_val     = kv;
    @(posedge clk);
    model_clock(kp, kv);
    #1;
    if (key_strobe) nstrobe++;
    check_model();
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_d1"}, disp_val, 4'd0);
    chk({tag, "_d2"}, disp_val2, 4'd0);
    chk({tag, "_d3"}, disp_val3, 4'd0);
    chk({tag, "_rec"}, {3'b0, is_record}, 4'd0);
    chk({tag, "_strobe"}, {3'b0, key_strobe}, 4'd0);
    chk({tag, "_last"}, last_key, 4'd0);
  endtask

  // Asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    #3;
    rst = 1'b1;
    #1;
    check_zero_outputs(tag);
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic press(input logic [3:0] k);
    int s0;
    s0 = nstrobe;
    for (int i = 0; i < D + 3; i++) step(1'b1, k);
    for (int i = 0; i < D + 2; i++) step(1'b0, k);
    chk("press_strobes", 4'(nstrobe - s0), 4'd1);
  endtask

  press_vec_t tbl [12];

  initial begin
    int s0, at;
    logic [3:0] k;
    int dur;
    logic kp;

    tbl[0]  = '{4'h1, 4'd0, 4'd0, 4'd1, 1'b0};
    tbl[1]  = '{4'h2, 4'd0, 4'd1, 4'd2, 1'b0};
    tbl[2]  = '{4'h3, 4'd1, 4'd2, 4'd3, 1'b0};
    tbl[3]  = '{4'h4, 4'd2, 4'd3, 4'd4, 1'b0};
    tbl[4]  = '{4'hF, 4'd0, 4'd2, 4'd3, 1'b0};
    tbl[5]  = '{4'hA, 4'd0, 4'd2, 4'd3, 1'b1};
    tbl[6]  = '{4'hA, 4'd0, 4'd2, 4'd3, 1'b0};
    tbl[7]  = '{4'hC, 4'd0, 4'd0, 4'd0, 1'b0};
    tbl[8]  = '{4'h9, 4'd0, 4'd0, 4'd9, 1'b0};
    tbl[9]  = '{4'h8, 4'd0, 4'd9, 4'd8, 1'b0};
    tbl[10] = '{4'hB, 4'd0, 4'd9, 4'd8, 1'b0};
    tbl[11] = '{4'h7, 4'd9, 4'd8, 4'd7, 1'b0};

    model_reset();
    #2;
    do_reset("rst0");

    // Key 5 held 20 cycles: strobe only on the 5th sampled edge.
    s0 = nstrobe; at = -1;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 4'h5);
      if (key_strobe) at = i;
    end
    chk("k5_edge", 4'(at), 4'd4);
    for (int i = 0; i < D + 2; i++) step(1'b0, 4'h0);
    chk("k5_count", 4'(nstrobe - s0), 4'd1);
    chk("k5_d3", disp_val3, 4'd5);
    chk("k5_last", last_key, 4'd5);

    // Bouncing press, then bouncing release.
    s0 = nstrobe; at = -1;
    for (int i = 0; i < 25; i++) begin
      step(i >= 10 || ((i / 2) % 2 == 0), 4'h7);
      if (key_strobe) at = i;
    end
    chk("bounce_edge", 4'(at), 4'd12);
    chk("bounce_count", 4'(nstrobe - s0), 4'd1);
    s0 = nstrobe;
    step(1'b0, 4'h7); step(1'b0, 4'h7); step(1'b1, 4'h7);
    for (int i = 0; i < D + 3; i++) step(1'b0, 4'h7);
    chk("rel_bounce_count", 4'(nstrobe - s0), 4'd0);
    chk("bounce_d2", disp_val2, 4'd5);
    chk("bounce_d3", disp_val3, 4'd7);

    // Code changes 3 -> 8 while held in the stability window.
    s0 = nstrobe; at = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, (i < 2) ? 4'h3 : 4'h8);
      if (key_strobe) at = i;
      chk("chg_no3", {3'b0, last_key == 4'h3}, 4'd0);
    end
    chk("chg_edge", 4'(at), 4'd6);
    chk("chg_last", last_key, 4'h8);
    chk("chg_d3", disp_val3, 4'd8);
    for (int i = 0; i < D + 2; i++) step(1'b0, 4'h0);

    // Table of presses from a clean reset.
    do_reset("rst1");
    for (int i = 0; i < 12; i++) begin
      press(tbl[i].key);
      chk("tbl_d1", disp_val, tbl[i].e1);
      chk("tbl_d2", disp_val2, tbl[i].e2);
      chk("tbl_d3", disp_val3, tbl[i].e3);
      chk("tbl_rec", {3'b0, is_record}, {3'b0, tbl[i].erec});
      chk("tbl_last", last_key, tbl[i].key);
    end

    // Reset while HELD with digits 1,2,3 and record on; key stays down across reset.
    do_reset("rst2");
    press(4'h1); press(4'h2); press(4'h3); press(4'hA);
    for (int i = 0; i < D + 3; i++) step(1'b1, 4'hB);
    chk("pre_rst_rec", {3'b0, is_record}, 4'd1);
    do_reset("rst_held");
    s0 = nstrobe; at = -1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'hB);
      if (key_strobe) at = i;
    end
    chk("post_rst_edge", 4'(at), 4'd4);
    chk("post_rst_count", 4'(nstrobe - s0), 4'd1);
    for (int i = 0; i < D + 2; i++) step(1'b0, 4'h0);

    // Random activity with runs long enough to cross the debounce window.
    for (int n = 0; n < 120; n++) begin
      kp  = 1'($urandom_range(0, 1));
      k   = 4'($urandom_range(0, 15));
      dur = $urandom_range(1, 9);
      for (int j = 0; j < dur; j++) begin
        if ($urandom_range(0, 7) == 0) k = 4'($urandom_range(0, 15));
        step(kp, k);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
